// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// one shift per clock.
//
// Timing: for a start accepted on edge E0, the W shifts occur on edges
// E0+1..E0+W. The result is registered on edge E0+W, together with the
// last shift. done is high for the cycle that follows that edge. The next
// conversion can be accepted on edge E0+W+2.
//
// Parameters
//   W       width of the binary input (1..27)
//   DIGITS  number of BCD output digits (1..8)
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous active-high reset; clears all state
//   start     conversion request; sampled only in IDLE
//   bin       unsigned value; sampled on the edge that accepts start
//   busy      high in SHIFT and DONE (W+1 cycles per conversion)
//   done      one-cycle pulse; bcd/overflow are updated in this cycle
//   bcd       DIGITS nibbles; digit k at [4k+3:4k]; held between done pulses
//   overflow  set with done when bin exceeds 10^DIGITS-1; held with bcd
module bin_to_bcd_seq #(
  parameter int W      = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // The scratch register has one extra nibble so that a carry out of the
  // top displayed digit never wraps into the digits that are shown.
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(W + 1);

  function automatic logic [31:0] max_value(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = max_value(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    sh_reg;
  logic [SW-1:0]   scratch_reg;
  logic [CW-1:0]   cnt_reg;
  logic            ovf_reg;

  logic [SW-1:0]   adj;
  logic [SW+W-1:0] cat_next;
  logic [SW-1:0]   scratch_next;
  logic [W-1:0]    sh_next;

  // Add 3 to every nibble that is 5 or more. The nibble then carries
  // correctly into the next decimal digit when the shift doubles it.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = scratch_reg[4*gi +: 4];
      assign adj[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  // Shift {scratch, shiftreg} left by one. The MSB of the binary register
  // enters bit 0 of the scratch register.
  assign cat_next     = {adj, sh_reg} << 1;
  assign scratch_next = cat_next[SW+W-1:W];
  assign sh_next      = cat_next[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sh_reg      <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_reg      <= bin;
            scratch_reg <= '0;
            cnt_reg     <= CW'(W);
            ovf_reg     <= (32'(bin) > MAX_VAL);
            busy        <= 1'b1;
            state_reg   <= SHIFT;
          end
        end

        SHIFT: begin
          sh_reg      <= sh_next;
          scratch_reg <= scratch_next;
          cnt_reg     <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            // Last shift. Register the result from the post-shift value
            // so that done and bcd appear in the same cycle.
            state_reg <= DONE;
            done      <= 1'b1;
            if (ovf_reg) begin
              bcd      <= {(4*DIGITS){1'b1}};
              overflow <= 1'b1;
            end else begin
              bcd      <= scratch_next[4*DIGITS-1:0];
              overflow <= 1'b0;
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the seven-segment decoder stage. A `W`-bit unsigned binary value is converted by iterative shift-add-3 (double dabble), one shift per clock. The result is `DIGITS` registered BCD nibbles, each wired directly to the 4-bit value input of one per-digit hex decoder instance. It replaces direct hex display of counters and sums wherever the board shows decimal.

## Interface
- `W`, default 20: width of the binary input; legal range 1..27.
- `DIGITS`, default 6: number of BCD output digits; legal range 1..8. Requires 10^DIGITS − 1 < 2^27.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset; clears all state immediately, independent of `clk`.
- `start` input 1: request a conversion; sampled only in IDLE.
- `bin` input W: unsigned value to convert; sampled on the same edge that accepts `start`.
- `busy` output 1: high while a conversion is in progress (SHIFT and DONE states).
- `done` output 1: single-cycle pulse; `bcd` and `overflow` are valid and updated in this cycle.
- `bcd` output 4*DIGITS: result, digit k at bits [4k+3:4k], where digit 0 is least significant. Held stable between `done` pulses.
- `overflow` output 1: set with `done` when the input exceeds 10^DIGITS − 1. Held with `bcd`.

## Operation
- Internal state:
  - binary shift register, W bits.
  - scratch BCD register of DIGITS+1 nibbles; the extra nibble absorbs carries.
  - shift counter, ceil(log2(W+1)) bits.
  - overflow latch.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `busy`=0. If `start`=1, load `bin` into the shift register and clear the scratch register.
  - Set the counter to W and the overflow latch to (`bin` > 10^DIGITS − 1), then go to SHIFT.
- SHIFT, one iteration per cycle:
  - Each scratch nibble ≥ 5 gets +3 (4-bit add, no carry out of the nibble).
  - Then shift {scratch, shiftreg} left by 1, with the MSB of the shift register entering scratch bit 0.
  - Decrement the counter. Move to DONE when the counter reaches 1 before decrement, i.e. exactly W shifts have occurred.
- DONE:
  - If the overflow latch is clear, `bcd` ← low DIGITS nibbles of scratch and `overflow` ← 0.
  - Otherwise `bcd` ← all nibbles 4'hF (sentinel display "FF…F") and `overflow` ← 1.
  - `done`=1 for this one cycle, then return to IDLE.
- `start` in SHIFT or DONE is ignored with no queuing. `bin` changes outside the accept edge have no effect.
- `start` held high continuously: back-to-back conversions; a new one is accepted in each IDLE cycle.
- Reset values (asynchronous):
  - FSM=IDLE, `busy`=0, `done`=0, `bcd`=0 (displays all zeros), `overflow`=0.
  - Counter and shift/scratch registers are 0.
- Reset mid-conversion aborts immediately. No `done` is issued and the previous `bcd` is lost (becomes 0).

## Timing
- `start` sampled at edge E0 → SHIFT during cycles E0..E0+W−1.
- `done` is high in the cycle after edge E0+W, with `bcd`/`overflow` updated on that same edge E0+W.
- `busy` is high from E0 through the cycle containing `done` (W+1 cycles).
- Earliest next accept is edge E0+W+2. Throughput is one conversion per W+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `rst` deassertion is taken synchronously by the surrounding design. The block makes no assumption about the first post-reset edge beyond IDLE behaviour.

## Test plan
- Reset with `start` toggling → `busy`=0, `done`=0, `bcd`=24'h000000, `overflow`=0 throughout. Hold reset for 3 cycles and release; still idle.
- W=20, DIGITS=6, `bin`=123456, one-cycle `start` → `done` exactly 21 cycles after the accept edge, `bcd`=24'h123456, `overflow`=0, `busy` high 21 cycles.
- Boundary values: `bin`=0 → 24'h000000; `bin`=999999 → 24'h999999, `overflow`=0; `bin`=1000000 → 24'hFFFFFF, `overflow`=1; `bin`=20'hFFFFF → 24'hFFFFFF, `overflow`=1.
- Ignored starts:
  - `start` pulsed at cycles 5 and 20 of a running conversion of 4321, with `bin` changed to 777 → single `done`, `bcd`=24'h004321.
  - A following start with 777 gives 24'h000777.
- Back-to-back: `start` held high with `bin` = 1, 10, 100 on successive accept edges → three `done` pulses spaced 22 cycles apart, `bcd` = 24'h000001, 24'h000010, 24'h000100.
- Reset at cycle 10 of a conversion of 555555 → outputs are 0 immediately (before the next edge). No `done` follows; the next conversion of 42 yields 24'h000042.
